// File: rtl/tt3_cond_pkg.sv
// Shared types and widths for the tt3 input conditioner.
// No logic; imported by the conditioner top.
package tt3_cond_pkg;

  localparam int TT3_W    = 3;
  localparam int CHGCNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2
  } state_t;

endpackage

// File: rtl/tt3_sync_bit.sv
// Single-bit SYNC_STAGES-deep synchronizer; latency SYNC_STAGES cycles, no backpressure.
module tt3_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/tt3_input_conditioner.sv
// Synchronize + debounce raw_in into a committed {in1,in2,in3} with valid/ready; TT3_COND_CHGCNT_EN adds chg_cnt.
// Latency SYNC_STAGES+HOLD_CYCLES; data and out_valid hold until out_ready, newer inputs collapse to the latest.
module tt3_input_conditioner
  import tt3_cond_pkg::*;
#(
  parameter int               HOLD_CYCLES = 4,
  parameter logic [TT3_W-1:0] RESET_VEC   = 3'b000,
  parameter int               SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [TT3_W-1:0]    raw_in,
  input  logic                out_ready,
`ifdef TT3_COND_CHGCNT_EN
  output logic [CHGCNT_W-1:0] chg_cnt,
`endif
  output logic                in1,
  output logic                in2,
  output logic                in3,
  output logic                out_valid,
  output logic                busy
);

  localparam int               CNT_W   = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);

  logic [TT3_W-1:0] w_sync;
  logic             w_accept;

  state_t           r_state;
  logic [TT3_W-1:0] r_committed;
  logic [TT3_W-1:0] r_cand;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;

  for (genvar g = 0; g < TT3_W; g++) begin : g_sync
    tt3_sync_bit #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .i_d  (raw_in[g]),
      .o_q  (w_sync[g])
    );
  end

  assign w_accept = r_out_valid & out_ready;

  // r_cnt counts consecutive cycles the candidate has been seen, including the first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_committed <= RESET_VEC;
      r_cand      <= RESET_VEC;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_sync != r_committed) begin
            r_cand <= w_sync;
            if (HOLD_CYCLES == 1) begin
              r_committed <= w_sync;
              r_cnt       <= '0;
              r_state     <= PRESENT;
              r_out_valid <= 1'b1;
            end else begin
              r_cnt   <= CNT_W'(1);
              r_state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (w_sync == r_committed) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else if (w_sync != r_cand) begin
            r_cand <= w_sync;
            r_cnt  <= CNT_W'(1);
          end else if (r_cnt == HOLD_M1) begin
            r_committed <= r_cand;
            r_cnt       <= '0;
            r_state     <= PRESENT;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        PRESENT: begin
          if (w_accept) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_cnt       <= '0;
        end
      endcase
    end
  end

  assign {in1, in2, in3} = r_committed;
  assign out_valid       = r_out_valid;
  assign busy            = (r_state != IDLE);

`ifdef TT3_COND_CHGCNT_EN
  logic [CHGCNT_W-1:0] r_chg_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chg_cnt <= '0;
    end else if (w_accept && (r_chg_cnt != '1)) begin
      r_chg_cnt <= r_chg_cnt + CHGCNT_W'(1);
    end
  end

  assign chg_cnt = r_chg_cnt;
`endif

endmodule

// File: tb/tb_tt3_input_conditioner.sv
// Bench for tt3_input_conditioner: vector table, corner sequences, randomized run vs. run-length reference model.
module tb_tt3_input_conditioner;

  localparam int         HOLD = 4;
  localparam int         SYNC = 2;
  localparam logic [2:0] RV   = 3'b000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] raw_in;
  logic       out_ready;
  logic       in1, in2, in3, out_valid, busy;
`ifdef TT3_COND_CHGCNT_EN
  logic [7:0] chg_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tt3_input_conditioner #(
    .HOLD_CYCLES(HOLD),
    .RESET_VEC  (RV),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .raw_in   (raw_in),
    .out_ready(out_ready),
`ifdef TT3_COND_CHGCNT_EN
    .chg_cnt  (chg_cnt),
`endif
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .out_valid(out_valid),
    .busy     (busy)
  );

  // Reference: commit once the same non-committed sync value is seen on HOLD
  // consecutive edges while not presenting; sync is raw_in delayed SYNC edges.
  logic [2:0] m_q[$];
  logic [2:0] m_committed;
  logic [2:0] m_last;
  int         m_run;
  bit         m_pres;
  int         m_chg;

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < SYNC; i++) m_q.push_back(3'b000);
    m_committed = RV;
    m_last      = RV;
    m_run       = 0;
    m_pres      = 1'b0;
    m_chg       = 0;
  endtask

  task automatic model_step();
    logic [2:0] s;
    s = m_q.pop_front();
    m_q.push_back(raw_in);
    if (m_pres) begin
      if (out_ready) begin
        m_pres = 1'b0;
        if (m_chg < 255) m_chg++;
      end
    end else if (s == m_committed) begin
      m_run = 0;
    end else begin
      if (m_run > 0 && s == m_last) m_run++;
      else begin
        m_run  = 1;
        m_last = s;
      end
      if (m_run == HOLD) begin
        m_committed = s;
        m_pres      = 1'b1;
        m_run       = 0;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_model(input string name);
    logic [4:0] got, exp;
    got = {in1, in2, in3, out_valid, busy};
    exp = {m_committed, m_pres, (m_pres || m_run > 0)};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {vec,vld,bsy}=%b, expected %b at %0t", name, got, exp, $time);
    end
`ifdef TT3_COND_CHGCNT_EN
    chk({name, "_chg"}, 32'(chg_cnt), 32'(m_chg));
`endif
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    raw_in    = 3'b111;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {29'd0, in1, in2, in3, out_valid, busy} >> 2, 32'(RV));
    chk("reset_vld_bsy", {30'd0, out_valid, busy}, 32'd0);
`ifdef TT3_COND_CHGCNT_EN
    chk("reset_chg", 32'(chg_cnt), 32'd0);
`endif
    raw_in = 3'b000;
    rst_n  = 1'b1;
    model_reset();
  endtask

  task automatic wait_valid(input string name, input int budget, output int k);
    k = 0;
    while (!out_valid && k < budget) begin
      tick();
      k++;
    end
    if (!out_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: out_valid timeout after %0d cycles, expected 1", name, k);
    end
  endtask

  typedef struct {
    logic [2:0] raw;
    logic       rdy;
    logic [2:0] vec;
    logic       vld;
    logic       bsy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int  k;
    bit  saw_001;
    int  rdy_bias;

    // Clean change 000->011, then a 2-cycle glitch to 101 that must be rejected.
    tbl[0]  = '{3'b011, 1'b1, 3'b000, 1'b0, 1'b0};
    tbl[1]  = '{3'b011, 1'b1, 3'b000, 1'b0, 1'b0};
    tbl[2]  = '{3'b011, 1'b1, 3'b000, 1'b0, 1'b1};
    tbl[3]  = '{3'b011, 1'b1, 3'b000, 1'b0, 1'b1};
    tbl[4]  = '{3'b011, 1'b1, 3'b000, 1'b0, 1'b1};
    tbl[5]  = '{3'b011, 1'b1, 3'b011, 1'b1, 1'b1};
    tbl[6]  = '{3'b011, 1'b1, 3'b011, 1'b0, 1'b0};
    tbl[7]  = '{3'b011, 1'b1, 3'b011, 1'b0, 1'b0};
    tbl[8]  = '{3'b101, 1'b1, 3'b011, 1'b0, 1'b0};
    tbl[9]  = '{3'b101, 1'b1, 3'b011, 1'b0, 1'b0};
    tbl[10] = '{3'b011, 1'b1, 3'b011, 1'b0, 1'b1};
    tbl[11] = '{3'b011, 1'b1, 3'b011, 1'b0, 1'b1};
    tbl[12] = '{3'b011, 1'b1, 3'b011, 1'b0, 1'b0};
    tbl[13] = '{3'b011, 1'b1, 3'b011, 1'b0, 1'b0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_after_reset", {27'd0, in1, in2, in3, out_valid, busy}, {27'd0, RV, 2'b00});
    end

    for (int i = 0; i < 14; i++) begin
      raw_in    = tbl[i].raw;
      out_ready = tbl[i].rdy;
      tick();
      n_cmp++;
      if ({in1, in2, in3, out_valid, busy} !== {tbl[i].vec, tbl[i].vld, tbl[i].bsy}) begin
        n_bad++;
        $display("FAIL table[%0d]: got {vec,vld,bsy}=%b, expected %b", i,
                 {in1, in2, in3, out_valid, busy}, {tbl[i].vec, tbl[i].vld, tbl[i].bsy});
      end
    end

    // Candidate restart: 001 settles 2 cycles, then 110 replaces it.
    do_reset();
    raw_in = 3'b001;
    tick();
    tick();
    raw_in  = 3'b110;
    saw_001 = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
      if (out_valid && {in1, in2, in3} == 3'b001) saw_001 = 1'b1;
    end
    chk("restart_latency", 32'(k), 32'(SYNC + HOLD));
    chk("restart_vec", {29'd0, in1, in2, in3}, 32'b110);
    chk("restart_no_001", 32'(saw_001), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("restart_accept", {30'd0, out_valid, busy}, 32'd0);

    // Backpressure: 010 held 20 cycles while 111 waits behind it.
    do_reset();
    raw_in = 3'b010;
    wait_valid("bp_first", 20, k);
    chk("bp_first_latency", 32'(k), 32'(SYNC + HOLD));
    raw_in = 3'b111;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_hold", {28'd0, in1, in2, in3, out_valid}, {28'd0, 3'b010, 1'b1});
    end
    out_ready = 1'b1;
    tick();
    chk("bp_accept", {27'd0, in1, in2, in3, out_valid, busy}, {27'd0, 3'b010, 2'b00});
    tick();
    chk("bp_settle_busy", {30'd0, out_valid, busy}, 32'b01);
    k = 1;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    // Counted from the accept edge: one idle pickup edge plus HOLD-1 settling edges.
    chk("bp_second_latency", 32'(k), 32'(HOLD));
    chk("bp_second_vec", {29'd0, in1, in2, in3}, 32'b111);
    tick();

    // Async reset while presenting.
    do_reset();
    raw_in = 3'b101;
    wait_valid("arst_present", 20, k);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_outputs", {27'd0, in1, in2, in3, out_valid, busy}, {27'd0, RV, 2'b00});
`ifdef TT3_COND_CHGCNT_EN
    chk("arst_chg", 32'(chg_cnt), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    raw_in = 3'b000;
    model_reset();

    // Randomized run against the reference model, varying downstream readiness.
    for (int seg = 0; seg < 6; seg++) begin
      rdy_bias = seg % 4;
      for (int i = 0; i < 500; i++) begin
        if ($urandom_range(0, 7) == 0) raw_in = 3'($urandom_range(0, 7));
        out_ready = ($urandom_range(0, 3) <= rdy_bias);
        tick();
        check_model("random");
      end
    end

`ifdef TT3_COND_CHGCNT_EN
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      raw_in = raw_in ^ 3'b111;
      wait_valid("chg_loop", 20, k);
      tick();
    end
    chk("chg_saturate", 32'(chg_cnt), 32'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tt3_input_conditioner.md
Name: tt3_input_conditioner

Overview:
- Upstream stage for the 3-input truth-table logic blocks.
- Synchronizes three asynchronous raw inputs and filters them with a persistence (debounce) window.
- Presents a stable committed vector in1/in2/in3 with a valid/ready handshake, so the downstream truth-table gate only sees settled, acknowledged combinations.

Parameters:
- HOLD_CYCLES, 4, consecutive cycles a new synchronized vector must stay unchanged before commit; legal range 1..255.
- RESET_VEC, 3'b000, committed vector value after reset, ordered {in1,in2,in3}.
- SYNC_STAGES, 2, synchronizer flops per raw input; legal range 2..3.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- raw_in  input  3  unsynchronized inputs; bit2=in1, bit1=in2, bit0=in3.
- out_ready  input  1  downstream accepts the committed vector.
- in1  output  1  committed bit 2.
- in2  output  1  committed bit 1.
- in3  output  1  committed bit 0.
- out_valid  output  1  committed vector is new and unacknowledged.
- busy  output  1  high while in SETTLE or PRESENT.

Behaviour:
- Reset (rst_n=0, async): sync flops=0, committed={in1,in2,in3}=RESET_VEC, cand_q=RESET_VEC, cnt=0, state=IDLE, out_valid=0, busy=0. Release is synchronous to clk.
- sync = raw_in after SYNC_STAGES flops. Latency from raw change to sync is SYNC_STAGES cycles.
- cnt width is $clog2(HOLD_CYCLES+1), zero-extended in all compares.
- FSM:
  - IDLE:
    - sync==committed: stay.
    - Otherwise: cand_q<=sync, cnt<=1, go SETTLE.
    - If HOLD_CYCLES==1: commit immediately instead (committed<=sync, go PRESENT).
  - SETTLE:
    - sync==committed: glitch rejected; go IDLE, cnt<=0.
    - sync!=cand_q: cand_q<=sync, cnt<=1, stay.
    - sync==cand_q and cnt==HOLD_CYCLES-1: committed<=cand_q, go PRESENT.
    - Otherwise: cnt<=cnt+1.
  - PRESENT:
    - out_valid=1; committed is frozen.
    - On out_valid&&out_ready: go IDLE.
    - A pending different sync value is picked up from IDLE on the following cycle (one idle cycle minimum between presentations).
- out_valid is registered and high only in PRESENT. Once asserted it stays high with stable data until accepted.
- busy = (state!=IDLE).
- Input changes during PRESENT are ignored until return to IDLE; the latest sync value wins, and intermediate values are dropped.
- End-to-end latency from a clean raw change to out_valid: SYNC_STAGES + HOLD_CYCLES cycles.
- out_ready while out_valid=0 has no effect.
- Reset mid-SETTLE or mid-PRESENT: immediate return to reset values; the pending vector is discarded.

Optional Feature:
- TT3_COND_CHGCNT_EN defined:
  - Adds output chg_cnt[7:0], reset 0.
  - Increments on each accepted handshake (out_valid&&out_ready).
  - Saturates at 255.
- Not defined: port absent, no counter logic.

Decomposition:
- Shared package tt3_cond_pkg:
  - state enum (IDLE, SETTLE, PRESENT, 2-bit).
  - TT3_W=3 constant.
  - CHGCNT_W=8 constant.
- One natural sub-module: tt3_sync_bit, a SYNC_STAGES-deep single-bit synchronizer with async active-low reset, instantiated 3 times.

Test Plan:
- Reset value: hold rst_n=0 with raw_in=3'b111 -> in1..in3=RESET_VEC (000), out_valid=0, busy=0. After release with raw_in=000, outputs stay unchanged indefinitely.
- Clean change, HOLD_CYCLES=4, SYNC_STAGES=2, out_ready=1: raw_in 000->011 at cycle 0 -> out_valid high at cycle 6 with {in1,in2,in3}=011 for exactly 1 cycle, then busy=0.
- Glitch rejection: raw_in 000->101 for 2 cycles, then back to 000 -> busy pulses, out_valid never asserts, outputs remain 000.
- Candidate restart: raw_in 000->001, then 001->110 after 2 settled cycles -> commit value is 110, not 001, with out_valid 4 cycles after the sync of 110.
- Backpressure: out_ready=0 after commit of 010, raw_in then changes to 111 -> out_valid and 010 held stable for 20 cycles. Assert out_ready -> accept 010, then IDLE, SETTLE, and 111 presented HOLD_CYCLES+1 cycles later.
- Async reset in PRESENT: assert rst_n=0 mid-cycle while out_valid=1 -> out_valid=0 and outputs=RESET_VEC before the next clock edge. With TT3_COND_CHGCNT_EN, chg_cnt=0 and saturates at 255 after 300 handshakes.
